// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: turns tick/button pulses into digit-counter inc/clear strobes and runs the time-set FSM.
// Latency: a request sampled at edge N yields its strobes during cycle N+1, for exactly one cycle.
// Backpressure: tick/btn_up arriving while busy are dropped (not queued); btn_mode is always accepted.
module clock_time_ctrl #(
    parameter int DW      = 4,
    parameter int HR_MAX1 = 2,
    parameter int HR_MAX0 = 3
) (
    input  logic          clk_out,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          btn_mode,
    input  logic          btn_up,
    input  logic [DW-1:0] sec0,
    input  logic [DW-1:0] sec1,
    input  logic [DW-1:0] min0,
    input  logic [DW-1:0] min1,
    input  logic [DW-1:0] hr0,
    input  logic [DW-1:0] hr1,
    output logic [5:0]    inc,
    output logic          hr_clr,
    output logic          sec_clr,
    output logic [1:0]    mode,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_t;

    localparam logic [DW-1:0] D9    = DW'(9);
    localparam logic [DW-1:0] D5    = DW'(5);
    localparam logic [DW-1:0] HMAX1 = DW'(HR_MAX1);
    localparam logic [DW-1:0] HMAX0 = DW'(HR_MAX0);

    state_t     state;
    state_t     state_nxt;
    logic [5:0] inc_nxt;
    logic       hr_clr_nxt;
    logic       sec_clr_nxt;
    logic       busy_nxt;
    logic       sec_carry;
    logic       min_carry;
    logic       hr_wrap;
    logic       hour_req;

    // mode is simply the registered FSM state
    assign mode = state;

    // Decode the strobe pattern for this cycle's request against the current (pre-transition) state
    always_comb begin
        inc_nxt     = '0;
        hr_clr_nxt  = 1'b0;
        sec_clr_nxt = 1'b0;
        hour_req    = 1'b0;
        sec_carry   = (sec0 == D9) && (sec1 == D5);
        min_carry   = (min0 == D9) && (min1 == D5);
        hr_wrap     = (hr1 == HMAX1) && (hr0 == HMAX0);
        state_nxt   = state;

        if (btn_mode) begin
            case (state)
                ST_RUN:     state_nxt = ST_SET_HR;
                ST_SET_HR:  state_nxt = ST_SET_MIN;
                ST_SET_MIN: state_nxt = ST_SET_SEC;
                default:    state_nxt = ST_RUN;
            endcase
        end

        // While busy the counters have not yet absorbed the last strobe, so new requests are dropped
        if (!busy) begin
            case (state)
                ST_RUN: begin
                    if (tick) begin
                        inc_nxt[0] = 1'b1;
                        inc_nxt[1] = (sec0 == D9);
                        inc_nxt[2] = sec_carry;
                        inc_nxt[3] = sec_carry && (min0 == D9);
                        hour_req   = sec_carry && min_carry;
                    end
                end
                ST_SET_HR: begin
                    hour_req = btn_up;
                end
                ST_SET_MIN: begin
                    if (btn_up) begin
                        inc_nxt[2] = 1'b1;
                        inc_nxt[3] = (min0 == D9);
                    end
                end
                default: begin
                    sec_clr_nxt = btn_up;
                end
            endcase
        end

        // Hour advance is shared by the RUN carry and SET_HR; the day wrap clears instead of incrementing
        if (hour_req) begin
            if (hr_wrap) begin
                hr_clr_nxt = 1'b1;
            end else begin
                inc_nxt[4] = 1'b1;
                inc_nxt[5] = (hr0 == D9);
            end
        end

        busy_nxt = (|inc_nxt) | hr_clr_nxt | sec_clr_nxt;
    end

    // Register FSM state and all strobe outputs; async reset drops everything at once
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            inc     <= '0;
            hr_clr  <= 1'b0;
            sec_clr <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            inc     <= inc_nxt;
            hr_clr  <= hr_clr_nxt;
            sec_clr <= sec_clr_nxt;
            busy    <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: drives clock_time_ctrl with directed and random requests around emulated digit counters.
// Latency: each request is checked one cycle after it is sampled, then idle state is checked a cycle later.
// Backpressure: drop behaviour is exercised by holding a request across the busy cycle.
module tb_clock_time_ctrl;

    logic       clk_out = 1'b0;
    logic       rst_n   = 1'b0;
    logic       tick    = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up  = 1'b0;
    logic [3:0] dig [6];
    logic [5:0] inc;
    logic       hr_clr;
    logic       sec_clr;
    logic [1:0] mode;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int ref_t = 0;     // reference time of day in seconds
    int ref_mode = 0;  // reference set state 0..3

    clock_time_ctrl #(.DW(4), .HR_MAX1(2), .HR_MAX0(3)) dut (
        .clk_out (clk_out),
        .rst_n   (rst_n),
        .tick    (tick),
        .btn_mode(btn_mode),
        .btn_up  (btn_up),
        .sec0    (dig[0]),
        .sec1    (dig[1]),
        .min0    (dig[2]),
        .min1    (dig[3]),
        .hr0     (dig[4]),
        .hr1     (dig[5]),
        .inc     (inc),
        .hr_clr  (hr_clr),
        .sec_clr (sec_clr),
        .mode    (mode),
        .busy    (busy)
    );

    always #5 clk_out = ~clk_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] digit_of(input int t, input int i);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        case (i)
            0:       return 4'(s % 10);
            1:       return 4'(s / 10);
            2:       return 4'(m % 10);
            3:       return 4'(m / 10);
            4:       return 4'(h % 10);
            default: return 4'(h / 10);
        endcase
    endfunction

    function automatic int emu_time();
        return (int'(dig[5]) * 10 + int'(dig[4])) * 3600 +
               (int'(dig[3]) * 10 + int'(dig[2])) * 60 +
               (int'(dig[1]) * 10 + int'(dig[0]));
    endfunction

    task automatic preset(input int h, input int m, input int s);
        ref_t = h * 3600 + m * 60 + s;
        for (int i = 0; i < 6; i++) dig[i] = digit_of(ref_t, i);
    endtask

    // Reference: advance the time of day arithmetically, then derive which digits must step
    task automatic model(input bit tk, input bit bu, output int nt,
                         output logic [5:0] e_inc, output logic e_hc, output logic e_sc);
        nt    = ref_t;
        e_inc = '0;
        e_hc  = 1'b0;
        e_sc  = 1'b0;
        if (tk && ref_mode == 0)
            nt = (ref_t + 1) % 86400;
        else if (bu && ref_mode == 1)
            nt = ((ref_t / 3600 + 1) % 24) * 3600 + ref_t % 3600;
        else if (bu && ref_mode == 2)
            nt = (ref_t / 3600) * 3600 + (((ref_t / 60) % 60 + 1) % 60) * 60 + ref_t % 60;
        else if (bu && ref_mode == 3) begin
            nt   = ref_t - ref_t % 60;
            e_sc = 1'b1;
        end
        if (!e_sc) begin
            for (int i = 0; i < 6; i++)
                if (digit_of(nt, i) != digit_of(ref_t, i)) e_inc[i] = 1'b1;
            if (ref_t / 3600 == 23 && nt / 3600 == 0) begin
                e_hc       = 1'b1;
                e_inc[5:4] = 2'b00;
            end
        end
    endtask

    // Emulated digit counters absorb the strobes the DUT issued
    task automatic apply_strobes();
        logic [3:0] lim [6];
        lim[0] = 4'd9; lim[1] = 4'd5; lim[2] = 4'd9;
        lim[3] = 4'd5; lim[4] = 4'd9; lim[5] = 4'd2;
        for (int i = 0; i < 6; i++)
            if (inc[i]) dig[i] = (dig[i] == lim[i]) ? 4'd0 : dig[i] + 4'd1;
        if (sec_clr) begin dig[0] = 4'd0; dig[1] = 4'd0; end
        if (hr_clr)  begin dig[4] = 4'd0; dig[5] = 4'd0; end
    endtask

    task automatic txn(input string tag, input bit tk, input bit bu, input bit bm);
        int         nt;
        logic [5:0] e_inc;
        logic       e_hc, e_sc;
        @(negedge clk_out);
        tick = tk; btn_up = bu; btn_mode = bm;
        model(tk, bu, nt, e_inc, e_hc, e_sc);
        @(negedge clk_out);
        tick = 1'b0; btn_up = 1'b0; btn_mode = 1'b0;
        chk({tag, ".inc"},     32'(inc),     32'(e_inc));
        chk({tag, ".hr_clr"},  32'(hr_clr),  32'(e_hc));
        chk({tag, ".sec_clr"}, 32'(sec_clr), 32'(e_sc));
        chk({tag, ".busy"},    32'(busy),    32'((|e_inc) | e_hc | e_sc));
        if (bm) ref_mode = (ref_mode + 1) % 4;
        chk({tag, ".mode"},    32'(mode),    32'(ref_mode));
        apply_strobes();
        ref_t = nt;
        @(negedge clk_out);
        chk({tag, ".idle_inc"},  32'(inc),  32'd0);
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
        chk({tag, ".time"},      32'(emu_time()), 32'(ref_t));
    endtask

    // Hold a request across the busy cycle: only the first sampling may strobe
    task automatic drop_pair(input string tag, input bit use_up);
        int         nt;
        logic [5:0] e_inc;
        logic       e_hc, e_sc;
        @(negedge clk_out);
        tick = !use_up; btn_up = use_up;
        model(!use_up, use_up, nt, e_inc, e_hc, e_sc);
        @(negedge clk_out);
        chk({tag, ".first_inc"},  32'(inc),  32'(e_inc));
        chk({tag, ".first_busy"}, 32'(busy), 32'd1);
        apply_strobes();
        ref_t = nt;
        @(negedge clk_out);
        tick = 1'b0; btn_up = 1'b0;
        chk({tag, ".drop_inc"},  32'(inc),  32'd0);
        chk({tag, ".drop_busy"}, 32'(busy), 32'd0);
        chk({tag, ".time"},      32'(emu_time()), 32'(ref_t));
    endtask

    initial begin
        int h, m, s;
        preset(0, 0, 0);
        #12;
        chk("rst.inc",     32'(inc),     32'd0);
        chk("rst.hr_clr",  32'(hr_clr),  32'd0);
        chk("rst.sec_clr", 32'(sec_clr), 32'd0);
        chk("rst.busy",    32'(busy),    32'd0);
        chk("rst.mode",    32'(mode),    32'd0);
        @(negedge clk_out);
        rst_n = 1'b1;

        preset(12, 34, 56); txn("t12_34_56", 1, 0, 0);
        preset(9, 59, 59);  txn("t09_59_59", 1, 0, 0);
        preset(23, 59, 59); txn("t23_59_59", 1, 0, 0);

        preset(23, 15, 40);
        txn("sethr.mode", 0, 0, 1);
        txn("sethr.up", 0, 1, 0);
        for (int i = 0; i < 3; i++) txn("sethr.tick", 1, 0, 0);
        txn("sethr.m2", 0, 0, 1);
        txn("sethr.m3", 0, 0, 1);
        txn("sethr.m0", 0, 0, 1);

        preset(0, 59, 30);
        txn("setmin.m1", 0, 0, 1);
        txn("setmin.m2", 0, 0, 1);
        txn("setmin.up", 0, 1, 0);
        txn("setsec.m3", 0, 0, 1);
        txn("setsec.up", 0, 1, 0);
        txn("setsec.m0", 0, 0, 1);

        preset(10, 20, 30);
        drop_pair("drop_tick", 1'b0);
        txn("mode_and_tick", 1, 0, 1);
        txn("to_min", 0, 0, 1);
        drop_pair("drop_up", 1'b1);

        // Async reset in the middle of a SET_MIN strobe
        @(negedge clk_out);
        btn_up = 1'b1;
        @(posedge clk_out);
        #1;
        btn_up = 1'b0;
        chk("midrst.pre_inc", 32'(inc), 32'(6'b000100));
        rst_n = 1'b0;
        #1;
        chk("midrst.inc",  32'(inc),  32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.mode", 32'(mode), 32'd0);
        @(negedge clk_out);
        rst_n = 1'b1;
        ref_mode = 0;

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                h = $urandom_range(0, 23);
                m = $urandom_range(0, 1) ? 59 : $urandom_range(0, 59);
                s = $urandom_range(0, 1) ? 59 : $urandom_range(0, 59);
                preset(h, m, s);
            end
            txn("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Sequencing controller for the six BCD digit counters of the 24-hour clock (sec0, sec1, min0, min1, hr0, hr1).
- Converts the 1 Hz tick and the debounced mode/up buttons into single-cycle increment and clear strobes for the digit counters.
- Resolves the inter-digit carry chain centrally, including the 23:59:59 -> 00:00:00 day wrap, and runs the time-set state machine.
- Sits between the clock divider/button one-pulse logic and the digit counters. It reads back the digit values and owns no time registers itself.

Parameters:
- DW, 4, width of each BCD digit input.
- HR_MAX1, 2, hour tens value at which the day wrap is checked.
- HR_MAX0, 3, hour units value that, with HR_MAX1, forms the 23 -> 00 wrap.

Ports:
- clk_out  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tick  in  1  one-cycle 1 Hz advance request.
- btn_mode  in  1  one-cycle pulse that advances the set state.
- btn_up  in  1  one-cycle pulse that increments the selected field.
- sec0, sec1, min0, min1, hr0, hr1  in  DW each  current digit values from the counters.
- inc  out  6  increment strobes, bit0 = sec0 through bit5 = hr1.
- hr_clr  out  1  synchronous clear strobe to hr0 and hr1.
- sec_clr  out  1  synchronous clear strobe to sec0 and sec1.
- mode  out  2  current state: 0 = RUN, 1 = SET_HR, 2 = SET_MIN, 3 = SET_SEC.
- busy  out  1  high while any strobe is being output.

Behaviour:
- Reset (asynchronous, active-low):
  - mode = RUN.
  - inc = 0, hr_clr = 0, sec_clr = 0, busy = 0.
- All outputs are registered.
- Latency: a request sampled at edge N produces its strobes during cycle N+1, for exactly one cycle.
  - Digit values are sampled at the same edge N.
- Dropped requests: tick or btn_up arriving while busy = 1 is dropped and not queued.
  - The counters update on the edge after the strobe, so busy covers that gap.
- FSM transitions, on btn_mode: RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN.
  - btn_mode is never dropped.
- State RUN:
  - btn_up is ignored.
  - On tick: inc[0] = 1.
  - inc[1] if sec0 == 9.
  - inc[2] if sec0 == 9 and sec1 == 5.
  - inc[3] if additionally min0 == 9.
  - Hour carry is C = sec0 == 9 and sec1 == 5 and min0 == 9 and min1 == 5.
  - If C and hr1 == HR_MAX1 and hr0 == HR_MAX0: hr_clr = 1, with inc[5:4] = 0.
  - Else if C: inc[4] = 1, and inc[5] = 1 if hr0 == 9.
- State SET_HR:
  - tick is ignored; the clock stops while setting.
  - On btn_up: the same hour rules apply with C forced to 1; seconds and minutes are untouched.
  - Example: 23 -> 00 via hr_clr.
- State SET_MIN:
  - tick is ignored.
  - On btn_up: inc[2] = 1, and inc[3] = 1 if min0 == 9.
  - 59 -> 00 with no carry into the hour digits.
- State SET_SEC:
  - tick is ignored.
  - On btn_up: sec_clr = 1.
- Simultaneous btn_mode and tick/btn_up in the same cycle:
  - The increment is evaluated against the pre-transition state.
  - mode updates at the same edge.
- Digit wrap is owned by the counters: sec0/min0/hr0 wrap 9 -> 0, sec1/min1 wrap 5 -> 0, hr1 wraps 2 -> 0.
  - The controller relies only on the strobe pattern above.
- Reset mid-strobe: outputs go to 0 immediately (asynchronously). Nothing is retained.
- Illegal digit inputs (for example 24:xx) are not corrected. The carry rules apply literally.

Test Plan:
- Reset, then tick at 12:34:56 -> next cycle inc = 000001, busy = 1. One cycle later inc = 0 and busy = 0.
- RUN at 09:59:59, tick -> inc = 111111 for one cycle, hr_clr = 0. Time then reads 10:00:00.
- RUN at 23:59:59, tick -> inc = 001111 and hr_clr = 1 in the same cycle. Time then reads 00:00:00.
- btn_mode x1 at 23:15:40, then btn_up -> hr_clr = 1, inc = 000000. Then tick x3 -> no strobes. Time then reads 00:15:40.
- btn_mode x2 at 00:59:30, then btn_up -> inc = 001100 and no hour strobe. Then btn_mode, btn_up -> sec_clr = 1. Then btn_mode -> mode = 0. Time then reads 00:00:00.
- Drop and ordering checks:
  - tick in the cycle after a tick (busy = 1) -> dropped, only one inc[0] pulse.
  - btn_mode together with tick in RUN -> tick strobe issued and mode = 1.
  - rst_n low during a strobe -> inc = 0 immediately.
